// File: rtl/shift_register_pkg.sv
// shift_register_pkg: default word width and FSM state encoding for shift_register_piso
package shift_register_pkg;
  localparam int DEF_WIDTH = 16;
  typedef enum logic [1:0] {IDLE, SHIFT, PARITY} state_t;
endpackage

// File: rtl/shift_register_piso.sv
// shift_register_piso: MSB-first PISO (clk, reset, load, data_in -> ready, out, out_valid, done); define SHIFT_REGISTER_PISO_PARITY_EN to append an even-parity bit
import shift_register_pkg::*;
module shift_register_piso #(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] data_in,
  output logic             ready,
  output logic             out,
  output logic             out_valid,
  output logic             done
);
  localparam int CW = $clog2(WIDTH);
  state_t state, state_nxt;
  logic [WIDTH-1:0] sreg;
  logic [CW-1:0] cnt;
  logic last, accept;
  assign last = state == SHIFT && cnt == CW'(WIDTH - 1);
  assign out_valid = state != IDLE;
  assign ready = state == IDLE || done;
  assign accept = load && ready;
`ifdef SHIFT_REGISTER_PISO_PARITY_EN
  logic par;
  assign done = state == PARITY;
  assign out = state == SHIFT ? sreg[WIDTH-1] : (state == PARITY && par);
  always_comb state_nxt = accept ? SHIFT : (state == PARITY ? IDLE : (last ? PARITY : state));
  always_ff @(posedge clk)
    if (reset) par <= 1'b0;
    else if (accept) par <= ^data_in;
`else
  assign done = last;
  assign out = state == SHIFT && sreg[WIDTH-1];
  always_comb state_nxt = accept ? SHIFT : (last ? IDLE : state);
`endif
  always_ff @(posedge clk)
    if (reset) begin
      state <= IDLE;
      sreg <= '0;
      cnt <= '0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        sreg <= data_in;
        cnt <= '0;
      end else if (state == SHIFT) begin
        sreg <= sreg << 1;
        cnt <= last ? '0 : cnt + 1'b1;
      end
    end
endmodule
